// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into an in-order FIFO that drains
// one register-file write per cycle, with a bypass lookup over all pending writes.
module writeback_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alu_valid,
   input  logic [ADDR_W-1:0]       alu_rd,
   input  logic [DATA_W-1:0]       alu_data,
   output logic                    alu_ready,
   input  logic                    mem_valid,
   input  logic [ADDR_W-1:0]       mem_rd,
   input  logic [DATA_W-1:0]       mem_data,
   output logic                    mem_ready,
   input  logic                    flush,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   input  logic [ADDR_W-1:0]       fwd_addr1,
   input  logic [ADDR_W-1:0]       fwd_addr2,
   output logic                    fwd_hit1,
   output logic                    fwd_hit2,
   output logic [DATA_W-1:0]       fwd_data1,
   output logic [DATA_W-1:0]       fwd_data2,
   output logic [$clog2(DEPTH):0]  pending_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  alu_slot;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  free;
   logic [CNT_W-1:0]  n_push;
   logic              mem_push;
   logic              alu_push;
   logic              pop;

   // Readiness looks only at registered occupancy; a same-cycle pop earns no credit.
   assign free      = CNT_W'(DEPTH) - count;
   assign mem_ready = !reset && !flush && (free >= CNT_W'(1));
   assign alu_ready = !reset && !flush &&
                      (mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));

   // Writes to R0 complete the handshake but never occupy a slot.
   assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
   assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
   assign n_push    = CNT_W'(mem_push) + CNT_W'(alu_push);
   assign alu_slot  = wr_ptr + PTR_W'(mem_push);
   assign pop       = (count != '0);

   assign pending_count = count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         wr_en   <= 1'b0;
      end else begin
         wr_en <= pop;
         if (pop) begin
            wr_addr <= q[rd_ptr].rd;
            wr_data <= q[rd_ptr].data;
            rd_ptr  <= rd_ptr + PTR_W'(1);
         end
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         count  <= count + n_push - CNT_W'(pop);
      end
   end

   // NOTE: the entry storage has no reset; occupancy is tracked by count, so
   // stale slot contents are never observed.
   always_ff @(posedge clk) begin
      if (mem_push) q[wr_ptr]   <= entry_t'{rd: mem_rd, data: mem_data};
      if (alu_push) q[alu_slot] <= entry_t'{rd: alu_rd, data: alu_data};
   end

   logic [ADDR_W-1:0] look_addr [2];
   logic              look_hit  [2];
   logic [DATA_W-1:0] look_data [2];

   assign look_addr[0] = fwd_addr1;
   assign look_addr[1] = fwd_addr2;

   // Output stage has lowest priority; walking oldest-to-youngest lets the youngest match win.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         look_hit[p]  = 1'b0;
         look_data[p] = '0;
         if (wr_en && (wr_addr == look_addr[p])) begin
            look_hit[p]  = 1'b1;
            look_data[p] = wr_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (q[rd_ptr + PTR_W'(i)].rd == look_addr[p])) begin
               look_hit[p]  = 1'b1;
               look_data[p] = q[rd_ptr + PTR_W'(i)].data;
            end
         end
         if (reset || (look_addr[p] == '0)) begin
            look_hit[p]  = 1'b0;
            look_data[p] = '0;
         end
      end
   end

   assign fwd_hit1  = look_hit[0];
   assign fwd_hit2  = look_hit[1];
   assign fwd_data1 = look_data[0];
   assign fwd_data2 = look_data[1];

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed corner cases plus random traffic,
// all compared against a queue-based reference model.
module tb_writeback_queue;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              alu_valid = 1'b0, mem_valid = 1'b0, flush = 1'b0;
   logic [ADDR_W-1:0] alu_rd = '0, mem_rd = '0, fwd_addr1 = '0, fwd_addr2 = '0;
   logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
   logic              alu_ready, mem_ready, wr_en, fwd_hit1, fwd_hit2;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data, fwd_data1, fwd_data2;
   logic [$clog2(DEPTH):0] pending_count;

   writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .pending_count(pending_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              mq[$];
   logic              m_wr_en   = 1'b0;
   logic [ADDR_W-1:0] m_wr_addr = '0;
   logic [DATA_W-1:0] m_wr_data = '0;

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Youngest pending entry first, then the write currently on the port.
   function automatic void model_fwd(input logic [ADDR_W-1:0] a, output logic hit,
                                     output logic [DATA_W-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a == '0) return;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].rd == a) begin
            hit = 1'b1;
            d   = mq[i].data;
            return;
         end
      end
      if (m_wr_en && (m_wr_addr == a)) begin
         hit = 1'b1;
         d   = m_wr_data;
      end
   endfunction

   // One clock cycle: drive after the falling edge, check before the rising edge,
   // advance the model at the rising edge.
   task automatic cycle(input logic av, input int ard, input int adat,
                        input logic mv, input int mrd, input int mdat,
                        input logic fl, input int fa1, input int fa2);
      int   free;
      logic exp_mr, exp_ar, h1, h2;
      logic [DATA_W-1:0] d1, d2;
      alu_valid = av; alu_rd = ADDR_W'(ard); alu_data = DATA_W'(adat);
      mem_valid = mv; mem_rd = ADDR_W'(mrd); mem_data = DATA_W'(mdat);
      flush = fl; fwd_addr1 = ADDR_W'(fa1); fwd_addr2 = ADDR_W'(fa2);
      #1;
      free   = DEPTH - mq.size();
      exp_mr = !fl && (free >= 1);
      exp_ar = !fl && (mv ? (free >= 2) : (free >= 1));
      model_fwd(fwd_addr1, h1, d1);
      model_fwd(fwd_addr2, h2, d2);
      check("mem_ready", 32'(mem_ready), 32'(exp_mr));
      check("alu_ready", 32'(alu_ready), 32'(exp_ar));
      check("pending_count", 32'(pending_count), 32'(mq.size()));
      check("wr_en", 32'(wr_en), 32'(m_wr_en));
      check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      check("wr_data", 32'(wr_data), 32'(m_wr_data));
      check("fwd_hit1", 32'(fwd_hit1), 32'(h1));
      check("fwd_data1", 32'(fwd_data1), 32'(d1));
      check("fwd_hit2", 32'(fwd_hit2), 32'(h2));
      check("fwd_data2", 32'(fwd_data2), 32'(d2));
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_wr_en = 1'b0;
      end else begin
         if (mq.size() > 0) begin
            ent_t e;
            e = mq.pop_front();
            m_wr_en = 1'b1; m_wr_addr = e.rd; m_wr_data = e.data;
         end else begin
            m_wr_en = 1'b0;
         end
         if (mv && exp_mr && (mem_rd != '0)) mq.push_back('{rd: mem_rd, data: mem_data});
         if (av && exp_ar && (alu_rd != '0)) mq.push_back('{rd: alu_rd, data: alu_data});
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input int fa);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, fa, 0);
   endtask

   // Assert reset between edges and check its effect before the next rising edge.
   task automatic async_reset(input int fa);
      alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 3'd5; mem_rd = 3'd6; flush = 1'b0;
      fwd_addr1 = ADDR_W'(fa); fwd_addr2 = ADDR_W'(fa);
      #2 reset = 1'b1;
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_pending", 32'(pending_count), 32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd0);
      check("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
      check("rst_fwd_hit2", 32'(fwd_hit2), 32'd0);
      mq.delete();
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
      @(negedge clk);
      reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
   endtask

   initial begin
      fwd_addr1 = 3'd1;
      #3;
      check("init_wr_en", 32'(wr_en), 32'd0);
      check("init_pending", 32'(pending_count), 32'd0);
      check("init_alu_ready", 32'(alu_ready), 32'd0);
      check("init_fwd_hit1", 32'(fwd_hit1), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single ALU result: bypass while queued, written two edges later.
      cycle(1, 3, 'h1234, 0, 0, 0, 0, 3, 0);
      idle(3, 3);

      // Same-register ALU and load together: load written first, ALU value forwarded.
      cycle(1, 2, 'hAAAA, 1, 2, 'h5555, 0, 2, 2);
      idle(4, 2);

      // Write to R0 handshakes but never queues or forwards.
      cycle(1, 0, 'hFFFF, 0, 0, 0, 0, 0, 0);
      idle(2, 0);

      // Saturation: keep both ports busy and watch readiness at the occupancy limit.
      for (int i = 0; i < 6; i++)
         cycle(1, 1 + (i % 7), 'h100 + i, 1, 7 - (i % 7), 'h200 + i, 0, 1 + (i % 7), 7);
      idle(5, 1);

      // Flush with three queued: the write on the port survives, the rest are dropped.
      cycle(1, 1, 'h0101, 1, 2, 'h0202, 0, 1, 2);
      cycle(1, 3, 'h0303, 1, 4, 'h0404, 0, 3, 4);
      cycle(1, 5, 'h0505, 1, 6, 'h0606, 1, 3, 4);
      idle(3, 3);

      // Asynchronous reset with three queued entries.
      cycle(1, 1, 'h1111, 1, 2, 'h2222, 0, 1, 2);
      cycle(1, 3, 'h3333, 1, 4, 'h4444, 0, 3, 4);
      async_reset(3);
      idle(3, 3);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom,
               $urandom_range(0, 99) < 50, $urandom_range(0, 7), $urandom,
               $urandom_range(0, 99) < 4, $urandom_range(0, 7), $urandom_range(0, 7));
         if (i == 300) async_reset($urandom_range(1, 7));
      end
      idle(4, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
